// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between the pad ring and the register bank.
// master = controller side, slave = spi_reg_bank side.
interface spi_reg_bank_if;
    logic copi;
    logic sclk;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport master (
        output copi, sclk, ncs,
        input  cipo, cipo_oe
    );

    modport slave (
        input  copi, sclk, ncs,
        output cipo, cipo_oe
    );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral register bank with commit strobe.
// Read-back over CIPO enabled by defining SPI_REG_BANK_READBACK_EN.
module spi_reg_bank #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr
);
    localparam int HDR_LEN   = 1 + ADDR_W;
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, OVER} state_t;

    // [0],[1] synchroniser, [2] edge-detect history
    logic [2:0] copi_q, sclk_q, ncs_q;
    logic       rise_q, ncs_rise_q, ncs_fall_q;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_W-1:0]     hdr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  rw_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic                  wr_stb_q;
    logic [ADDR_W-1:0]     wr_addr_q;

    logic [ADDR_W:0]       hdr_d;
    logic [DATA_W-1:0]     data_d;
    logic [ADDR_W-1:0]     sel_addr;
    logic                  hit;

`ifdef SPI_REG_BANK_READBACK_EN
    logic                  fall_q;
    logic [DATA_W-1:0]     shadow_q;
    logic                  oe_q;
    logic [DATA_W-1:0]     rd_d;
`endif

    // Synchronise the SPI pins and register edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copi_q     <= '0;
            sclk_q     <= '0;
            ncs_q      <= '1;
            rise_q     <= 1'b0;
            ncs_rise_q <= 1'b0;
            ncs_fall_q <= 1'b0;
        end else begin
            copi_q     <= {copi_q[1:0], spi.copi};
            sclk_q     <= {sclk_q[1:0], spi.sclk};
            ncs_q      <= {ncs_q[1:0], spi.ncs};
            rise_q     <= sclk_q[1] & ~sclk_q[2];
            ncs_rise_q <= ncs_q[1] & ~ncs_q[2];
            ncs_fall_q <= ~ncs_q[1] & ncs_q[2];
        end
    end

`ifdef SPI_REG_BANK_READBACK_EN
    // Falling SCLK pulse paces the read shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= ~sclk_q[1] & sclk_q[2];
        end
    end
`endif

    // Shift paths and register select for the current address
    always_comb begin
        hdr_d    = {hdr_q, copi_q[2]};
        data_d   = DATA_W'({data_q, copi_q[2]});
        sel_addr = (state_q == HDR) ? hdr_d[ADDR_W-1:0] : addr_q;
        hit      = 1'b0;
`ifdef SPI_REG_BANK_READBACK_EN
        rd_d     = '0;
`endif
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_addr == ADDR_W'(i)) begin
                hit  = 1'b1;
`ifdef SPI_REG_BANK_READBACK_EN
                rd_d = regs_q[i];
`endif
            end
        end
    end

    // Frame FSM: parse, commit on NCS rise, load/shift read shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hdr_q     <= '0;
            data_q    <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef SPI_REG_BANK_READBACK_EN
            shadow_q  <= '0;
            oe_q      <= 1'b0;
`endif
        end else begin
            wr_stb_q <= 1'b0;
            if (ncs_rise_q) begin
                if (state_q == DATA && rw_q && hit &&
                    cnt_q == CNT_W'(FRAME_LEN)) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == ADDR_W'(i)) regs_q[i] <= data_q;
                    end
                    wr_stb_q  <= 1'b1;
                    wr_addr_q <= addr_q;
                end
                state_q <= IDLE;
`ifdef SPI_REG_BANK_READBACK_EN
                oe_q    <= 1'b0;
`endif
            end else if (ncs_fall_q) begin
                // also restarts a frame already in progress
                state_q <= HDR;
                cnt_q   <= '0;
                hdr_q   <= '0;
                data_q  <= '0;
`ifdef SPI_REG_BANK_READBACK_EN
                oe_q    <= 1'b0;
`endif
            end else if (rise_q) begin
                unique case (state_q)
                    HDR: begin
                        hdr_q <= hdr_d[ADDR_W-1:0];
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(HDR_LEN - 1)) begin
                            rw_q    <= hdr_d[ADDR_W];
                            addr_q  <= hdr_d[ADDR_W-1:0];
                            state_q <= DATA;
`ifdef SPI_REG_BANK_READBACK_EN
                            if (!hdr_d[ADDR_W]) begin
                                oe_q     <= 1'b1;
                                shadow_q <= rd_d;
                            end
`endif
                        end
                    end
                    DATA: begin
                        if (cnt_q == CNT_W'(FRAME_LEN)) begin
                            state_q <= OVER;
`ifdef SPI_REG_BANK_READBACK_EN
                            oe_q    <= 1'b0;
`endif
                        end else begin
                            data_q <= data_d;
                            cnt_q  <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
`ifdef SPI_REG_BANK_READBACK_EN
            // the fall closing the last header bit keeps the MSB on CIPO
            else if (fall_q && state_q == DATA &&
                     cnt_q > CNT_W'(HDR_LEN)) begin
                shadow_q <= {shadow_q[DATA_W-2:0], 1'b0};
            end
`endif
        end
    end

    // Flatten the register file onto the output bus
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;

`ifdef SPI_REG_BANK_READBACK_EN
    assign spi.cipo_oe = oe_q;
    assign spi.cipo    = oe_q & shadow_q[DATA_W-1];
`else
    assign spi.cipo_oe = 1'b0;
    assign spi.cipo    = 1'b0;
`endif
endmodule
